alu_exec_unit: RTL

- Execute-stage ALU that directly consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the two register/immediate operands.
- Produces a registered result, zero flag and illegal-op flag over a valid/ready handshake toward the writeback/branch logic.
- Logic and arithmetic ops complete in one cycle. SLL/SRL use an iterative 1-bit-per-cycle shifter, trading latency for area; this makes the unit multi-cycle and stalls the issue side via in_ready.

---
 rtl/alu_exec_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result over a valid/ready handshake.
// Logic/arith ops finish in one cycle; SLL/SRL shift one bit per cycle.
module alu_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic [XLEN-1:0]      shreg_q, shreg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 shl_q, shl_d;

  logic                 accept;
  logic                 iss_shift;
  logic                 iss_illegal;
  logic [XLEN-1:0]      iss_result;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      shifted;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  assign shamt   = operand_b[SHAMT_W-1:0];
  assign shifted = shl_q ? (shreg_q << 1) : (shreg_q >> 1);

  // Decode the incoming op; a zero-amount shift completes like a 1-cycle op.
  always_comb begin
    iss_shift   = 1'b0;
    iss_illegal = 1'b0;
    iss_result  = '0;
    unique case (alu_control)
      OpAnd: iss_result = operand_a & operand_b;
      OpOr:  iss_result = operand_a | operand_b;
      OpAdd: iss_result = operand_a + operand_b;
      OpSub: iss_result = operand_a - operand_b;
      OpXor: iss_result = operand_a ^ operand_b;
      OpSlt: iss_result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OpSll, OpSrl: begin
        iss_result = operand_a;
        iss_shift  = (shamt != '0);
      end
      default: iss_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = shifted;
          zero_d    = (shifted == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready && !in_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (iss_shift) begin
        shreg_d = operand_a;
        cnt_d   = shamt;
        shl_d   = (alu_control == OpSll);
        state_d = StShift;
      end else begin
        result_d  = iss_result;
        zero_d    = (iss_result == '0);
        illegal_d = iss_illegal;
        state_d   = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      shl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      shl_q     <= shl_d;
    end
  end

endmodule
